snake_step_sched: RTL and testbench
===================================

Name: snake_step_sched

Overview:
- Game-step controller for the snake datapath.
- Converts per-frame ticks into movement step pulses.
- Buffers keypresses into a reversal-safe 2-entry direction queue.
- Runs apple placement through an LFSR candidate generator and an occupancy-query handshake with the body datapath, so an apple never lands on the snake.
- Sits between the keyboard/game-state FSM and the position-array datapath.

Parameters:
- STEP_FRAMES, 5: frame_ticks per movement step (min 2).
- MAX_TRIES, 16: apple candidates per spawn attempt before deferring.
- LFSR_SEED, 16'hACE1: LFSR value at reset and on init; must be nonzero.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- frame_tick  in  1  one-cycle pulse per video frame.
- run  in  1  1 = game running; 0 = paused, dead, or black screen.
- init  in  1  one-cycle pulse: restart game state.
- key_valid  in  1  one-cycle pulse: key_code is new.
- key_code  in  8  PS/2 code: 75 up, 72 down, 6B left, 74 right.
- step  out  1  one-cycle pulse: datapath advances the snake by one cell.
- dir  out  2  direction applied at step (0 up, 1 down, 2 left, 3 right).
- eat  in  1  one-cycle pulse from datapath: head reached the apple.
- apple_pos  out  13  {y[12:7], x[6:0]}, x 0..63, y 0..47.
- apple_valid  out  1  apple_pos is placed and drawable.
- occ_query  out  1  occupancy request.
- occ_pos  out  13  cell being queried; stable while occ_query=1.
- occ_ack  in  1  one-cycle response pulse.
- occ_hit  in  1  valid with occ_ack: 1 = cell occupied by the body.

Behaviour:
Reset (rst=1) and init, with rst taking priority:
- step=0, dir=3, queue empty, frame counter 0, apple_valid=0, occ_query=0, LFSR=LFSR_SEED.
- Apple FSM enters SPAWN with tries=0.
- apple_pos resets to 13'd6.

Step counter:
- Increments on frame_tick only while run=1; held when run=0.
- On the frame_tick at which the count equals period-1: counter goes to 0, and step is asserted on the next cycle (1-cycle latency).
- step is never asserted while run=0.

Direction queue (2 entries, FIFO):
- A key is valid only if it is one of the 4 codes; all other codes are ignored.
- Reference direction = queue tail, or dir if the queue is empty.
- Push only if the key differs from the reference and is not its opposite. Full queue: key dropped.
- On step: if the queue is non-empty, pop the head into dir in the same cycle that step is asserted; otherwise dir is unchanged.
- Key and pop in the same cycle: pop first, then the key is checked against the post-pop reference.
- init in the same cycle as a key: init wins and the key is dropped.

LFSR:
- 16-bit Fibonacci, taps 16/14/13/11, advances every cycle.
- Candidate x = lfsr[5:0].
- Candidate y = lfsr[13:8]; if y >= 48, use y-16.

Apple FSM:
- SPAWN: latch candidate into occ_pos, tries++, go to QUERY.
- QUERY: hold occ_query=1 until occ_ack.
  - occ_ack with hit=0: apple_pos <= occ_pos, apple_valid=1, go to PLACED; occ_query drops the cycle after ack.
  - occ_ack with hit=1 and tries<MAX_TRIES: go to SPAWN.
  - occ_ack with hit=1 and tries=MAX_TRIES: go to WAIT.
- PLACED: on eat, apple_valid=0 on the next cycle, tries=0, go to SPAWN. eat in any other state is ignored.
- WAIT: on frame_tick, tries=0, go to SPAWN.
- init in any state, including mid-QUERY: occ_query=0 next cycle and the FSM goes to SPAWN. A late occ_ack after an abort is ignored.
- run=0 does not stall the apple FSM.

Optional Feature:
SNAKE_SPEEDUP_EN
- Defined: the step period register starts at STEP_FRAMES. Each accepted eat decrements it by 1, floor 2. init/rst restore STEP_FRAMES.
- Undefined: the period is constant STEP_FRAMES and no period register exists.

Test Plan:
- rst, then run=1, 10 frame_ticks with STEP_FRAMES=5 -> exactly 2 step pulses, each 1 cycle after the 5th/10th tick; dir=3.
- dir=3, keys 75 then 6B before a step -> queue {0,2}; next step dir=0, following step dir=2. A third key before any step -> dropped.
- dir=3, key 6B (opposite) -> ignored; key 74 (same) -> ignored; queue stays empty.
- Bench answers occ_hit=1 on the first 3 queries, then 0 -> 4 queries issued; apple_valid=1 with apple_pos = 4th occ_pos, and x<=63, y<=47.
- Bench always answers hit=1 -> exactly 16 queries, FSM in WAIT, apple_valid=0; the next frame_tick restarts querying.
- init asserted while occ_query=1 -> occ_query=0 next cycle; a late ack is ignored; dir=3, queue empty, fresh query follows. With SNAKE_SPEEDUP_EN, 4 eats -> step spacing 5,4,3,2,2 frames.

Source files
------------

// File: rtl/snake_step_sched.sv
// snake_step_sched: game-step controller for the snake datapath.
// Turns frame ticks into step pulses, holds a reversal-safe 2-entry
// direction queue, and places apples from an LFSR candidate stream using
// an occupancy-query handshake with the body datapath.
// Optional build macro: SNAKE_SPEEDUP_EN. When defined, each eaten apple
// shortens the step period by one frame, with a floor of 2 frames.
module snake_step_sched #(
   parameter int unsigned STEP_FRAMES = 5,
   parameter int unsigned MAX_TRIES   = 16,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        run,
   input  logic        init,
   input  logic        key_valid,
   input  logic [7:0]  key_code,
   output logic        step,
   output logic [1:0]  dir,
   input  logic        eat,
   output logic [12:0] apple_pos,
   output logic        apple_valid,
   output logic        occ_query,
   output logic [12:0] occ_pos,
   input  logic        occ_ack,
   input  logic        occ_hit
);

   localparam int unsigned CNT_W  = $clog2(STEP_FRAMES + 1);
   localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
   localparam int unsigned DIR_W  = 2;
   localparam int unsigned POS_W  = 13;
   localparam int unsigned QCNT_W = 2;

   localparam logic [DIR_W-1:0] DIR_UP    = 2'd0;
   localparam logic [DIR_W-1:0] DIR_DOWN  = 2'd1;
   localparam logic [DIR_W-1:0] DIR_LEFT  = 2'd2;
   localparam logic [DIR_W-1:0] DIR_RIGHT = 2'd3;

   typedef struct packed {
      logic [5:0] y;
      logic [6:0] x;
   } cell_t;

   typedef enum logic [1:0] {
      ST_SPAWN,
      ST_QUERY,
      ST_PLACED,
      ST_WAIT
   } state_t;

   // rst and init restart identical state; rst simply dominates by OR
   logic clr;
   assign clr = rst | init;

   state_t state;
   state_t state_n;

   // ------------------------------------------------------------------
   // Step period: constant, or shrinking on each accepted eat
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] period;

`ifdef SNAKE_SPEEDUP_EN
   logic eat_accept;
   assign eat_accept = eat && (state == ST_PLACED);

   // Period register: one frame shorter per apple, never below 2
   always_ff @(posedge clk) begin
      if (clr) begin
         period <= CNT_W'(STEP_FRAMES);
      end else if (eat_accept && (period > CNT_W'(2))) begin
         period <= period - CNT_W'(1);
      end
   end
`else
   assign period = CNT_W'(STEP_FRAMES);
`endif

   // ------------------------------------------------------------------
   // Frame counter and step pulse
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] frame_cnt;
   logic             step_fire;

   // >= keeps the counter safe if the period shrinks below the count
   assign step_fire = run && frame_tick && (frame_cnt >= (period - CNT_W'(1)));

   // Count run-time frames; step fires one cycle after the last frame
   always_ff @(posedge clk) begin
      if (clr) begin
         frame_cnt <= '0;
         step      <= 1'b0;
      end else begin
         step <= step_fire;
         if (step_fire) begin
            frame_cnt <= '0;
         end else if (run && frame_tick) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Key decode and direction queue
   // ------------------------------------------------------------------
   logic             key_ok;
   logic [DIR_W-1:0] key_dir;

   // Map the four PS/2 arrow codes to directions; everything else is noise
   always_comb begin
      key_ok  = 1'b1;
      key_dir = DIR_UP;
      case (key_code)
         8'h75:   key_dir = DIR_UP;
         8'h72:   key_dir = DIR_DOWN;
         8'h6B:   key_dir = DIR_LEFT;
         8'h74:   key_dir = DIR_RIGHT;
         default: key_ok  = 1'b0;
      endcase
   end

   logic [DIR_W-1:0]  q_head;
   logic [DIR_W-1:0]  q_tail;
   logic [QCNT_W-1:0] q_cnt;
   logic [DIR_W-1:0]  q_head_n;
   logic [DIR_W-1:0]  q_tail_n;
   logic [QCNT_W-1:0] q_cnt_n;
   logic [DIR_W-1:0]  dir_n;
   logic [DIR_W-1:0]  ref_dir;
   logic              key_push;

   // Pop on step first, then test the key against the post-pop reference
   always_comb begin
      q_head_n = q_head;
      q_tail_n = q_tail;
      q_cnt_n  = q_cnt;
      dir_n    = dir;
      if (step_fire && (q_cnt != '0)) begin
         dir_n    = q_head;
         q_head_n = q_tail;
         q_cnt_n  = q_cnt - QCNT_W'(1);
      end
      if (q_cnt_n == '0) begin
         ref_dir = dir_n;
      end else if (q_cnt_n == QCNT_W'(1)) begin
         ref_dir = q_head_n;
      end else begin
         ref_dir = q_tail_n;
      end
      // opposite directions differ only in bit 0 (up/down, left/right)
      key_push = key_valid && key_ok
                 && (key_dir != ref_dir)
                 && (key_dir != (ref_dir ^ DIR_W'(1)))
                 && (q_cnt_n != QCNT_W'(2));
      if (key_push) begin
         if (q_cnt_n == '0) begin
            q_head_n = key_dir;
         end else begin
            q_tail_n = key_dir;
         end
         q_cnt_n = q_cnt_n + QCNT_W'(1);
      end
   end

   // Direction and queue registers; init drops any same-cycle key
   always_ff @(posedge clk) begin
      if (clr) begin
         dir    <= DIR_RIGHT;
         q_head <= DIR_UP;
         q_tail <= DIR_UP;
         q_cnt  <= '0;
      end else begin
         dir    <= dir_n;
         q_head <= q_head_n;
         q_tail <= q_tail_n;
         q_cnt  <= q_cnt_n;
      end
   end

   // ------------------------------------------------------------------
   // LFSR candidate generator
   // ------------------------------------------------------------------
   logic [15:0] lfsr;
   logic [5:0]  cand_y_raw;
   cell_t       cand;

   // Free-running Fibonacci LFSR, taps 16/14/13/11
   always_ff @(posedge clk) begin
      if (clr) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   // Fold y values 48..63 back onto the 48-row playfield
   always_comb begin
      cand_y_raw = lfsr[13:8];
      cand.x     = {1'b0, lfsr[5:0]};
      cand.y     = (cand_y_raw >= 6'd48) ? (cand_y_raw - 6'd16) : cand_y_raw;
   end

   // ------------------------------------------------------------------
   // Apple placement FSM
   // ------------------------------------------------------------------
   logic [TRY_W-1:0] tries;
   logic [TRY_W-1:0] tries_n;
   logic             occ_query_n;
   logic [POS_W-1:0] occ_pos_n;
   logic [POS_W-1:0] apple_pos_n;
   logic             apple_valid_n;

   // State register; init aborts any query in flight
   always_ff @(posedge clk) begin
      if (clr) begin
         state <= ST_SPAWN;
      end else begin
         state <= state_n;
      end
   end

   // Next-state: query until a free cell or the try budget runs out
   always_comb begin
      state_n = state;
      case (state)
         ST_SPAWN: state_n = ST_QUERY;
         ST_QUERY: begin
            if (occ_ack) begin
               if (!occ_hit) begin
                  state_n = ST_PLACED;
               end else if (tries >= TRY_W'(MAX_TRIES)) begin
                  state_n = ST_WAIT;
               end else begin
                  state_n = ST_SPAWN;
               end
            end
         end
         ST_PLACED: if (eat)        state_n = ST_SPAWN;
         ST_WAIT:   if (frame_tick) state_n = ST_SPAWN;
         default:   state_n = ST_SPAWN;
      endcase
   end

   // Output decode: next values for the registered handshake and apple
   always_comb begin
      tries_n       = tries;
      occ_query_n   = 1'b0;
      occ_pos_n     = occ_pos;
      apple_pos_n   = apple_pos;
      apple_valid_n = apple_valid;
      case (state)
         ST_SPAWN: begin
            occ_pos_n   = cand;
            tries_n     = tries + TRY_W'(1);
            occ_query_n = 1'b1;
         end
         ST_QUERY: begin
            occ_query_n = !occ_ack;
            if (occ_ack && !occ_hit) begin
               apple_pos_n   = occ_pos;
               apple_valid_n = 1'b1;
            end
         end
         ST_PLACED: begin
            if (eat) begin
               apple_valid_n = 1'b0;
               tries_n       = '0;
            end
         end
         ST_WAIT: begin
            if (frame_tick) begin
               tries_n = '0;
            end
         end
         default: ;
      endcase
   end

   // Registered apple and occupancy-query outputs
   always_ff @(posedge clk) begin
      if (clr) begin
         tries       <= '0;
         occ_query   <= 1'b0;
         occ_pos     <= '0;
         apple_pos   <= POS_W'(6);
         apple_valid <= 1'b0;
      end else begin
         tries       <= tries_n;
         occ_query   <= occ_query_n;
         occ_pos     <= occ_pos_n;
         apple_pos   <= apple_pos_n;
         apple_valid <= apple_valid_n;
      end
   end

endmodule

// File: tb/tb_snake_step_sched.sv
// tb_snake_step_sched: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a behavioural model of the step scheduler.
module tb_snake_step_sched;

   localparam int unsigned STEP_FRAMES = 5;
   localparam int unsigned MAX_TRIES   = 16;
   localparam logic [15:0] SEED        = 16'hACE1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_tick = 1'b0;
   logic        run = 1'b0;
   logic        init = 1'b0;
   logic        key_valid = 1'b0;
   logic [7:0]  key_code = 8'h00;
   logic        step;
   logic [1:0]  dir;
   logic        eat = 1'b0;
   logic [12:0] apple_pos;
   logic        apple_valid;
   logic        occ_query;
   logic [12:0] occ_pos;
   logic        occ_ack = 1'b0;
   logic        occ_hit = 1'b0;

   always #5 clk = ~clk;

   snake_step_sched #(
      .STEP_FRAMES(STEP_FRAMES),
      .MAX_TRIES  (MAX_TRIES),
      .LFSR_SEED  (SEED)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .run        (run),
      .init       (init),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .step       (step),
      .dir        (dir),
      .eat        (eat),
      .apple_pos  (apple_pos),
      .apple_valid(apple_valid),
      .occ_query  (occ_query),
      .occ_pos    (occ_pos),
      .occ_ack    (occ_ack),
      .occ_hit    (occ_hit)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum int {A_SPAWN, A_QUERY, A_PLACED, A_WAIT} amode_t;

   int          m_ticks, m_period, m_dir, m_tries, m_opos, m_apos;
   bit          m_step, m_oq, m_av;
   int          m_q[$];
   bit   [15:0] m_lfsr;
   amode_t      m_mode;

   function automatic int key_to_dir(input logic [7:0] code);
      case (code)
         8'h75:   return 0;
         8'h72:   return 1;
         8'h6B:   return 2;
         8'h74:   return 3;
         default: return -1;
      endcase
   endfunction

   function automatic int opposite(input int d);
      case (d)
         0:       return 1;
         1:       return 0;
         2:       return 3;
         default: return 2;
      endcase
   endfunction

   function automatic bit [15:0] lfsr_next(input bit [15:0] l);
      bit fb;
      fb = ^(l & 16'hB400);
      return {l[14:0], fb};
   endfunction

   function automatic int cand_cell(input bit [15:0] l);
      int x, y;
      x = int'(l) % 64;
      y = (int'(l) / 256) % 64;
      if (y >= 48) y = y - 16;
      return y * 128 + x;
   endfunction

   task automatic model_edge();
      int k, r;
      bit fire;
      fire = 1'b0;
      if (rst || init) begin
         m_ticks = 0; m_period = STEP_FRAMES; m_step = 0; m_dir = 3;
         m_q.delete(); m_lfsr = SEED; m_mode = A_SPAWN; m_tries = 0;
         m_oq = 0; m_av = 0; m_apos = 6;
         return;
      end
      if (run && frame_tick) begin
         m_ticks++;
         if (m_ticks >= m_period) begin
            m_ticks = 0;
            fire = 1'b1;
         end
      end
      m_step = fire;
      if (fire && m_q.size() > 0) m_dir = m_q.pop_front();
      k = key_to_dir(key_code);
      if (key_valid && k >= 0) begin
         r = (m_q.size() > 0) ? m_q[$] : m_dir;
         if (k != r && k != opposite(r) && m_q.size() < 2) m_q.push_back(k);
      end
      case (m_mode)
         A_SPAWN: begin
            m_opos = cand_cell(m_lfsr);
            m_tries++;
            m_oq = 1;
            m_mode = A_QUERY;
         end
         A_QUERY: begin
            if (occ_ack) begin
               m_oq = 0;
               if (!occ_hit) begin
                  m_apos = m_opos; m_av = 1; m_mode = A_PLACED;
               end else if (m_tries < int'(MAX_TRIES)) begin
                  m_mode = A_SPAWN;
               end else begin
                  m_mode = A_WAIT;
               end
            end
         end
         A_PLACED: begin
            if (eat) begin
               m_av = 0; m_tries = 0; m_mode = A_SPAWN;
`ifdef SNAKE_SPEEDUP_EN
               if (m_period > 2) m_period--;
`endif
            end
         end
         default: begin
            if (frame_tick) begin
               m_tries = 0; m_mode = A_SPAWN;
            end
         end
      endcase
      m_lfsr = lfsr_next(m_lfsr);
   endtask

   // ---------------- occupancy responder ----------------
   bit resp_en   = 1'b1;
   bit resp_rand = 1'b0;
   int hits_left = 0;    // -1: always hit
   int ack_wait  = 0;

   function automatic bit pick_hit();
      if (resp_rand) return ($urandom % 3) == 0;
      if (hits_left < 0) return 1'b1;
      if (hits_left > 0) begin
         hits_left--;
         return 1'b1;
      end
      return 1'b0;
   endfunction

   // ---------------- cycle driver ----------------
   int          n_queries = 0;
   int          n_steps   = 0;
   bit          prev_oq   = 1'b0;
   logic [12:0] last_qpos = '0;

   task automatic cycle();
      if (resp_en && m_oq) begin
         if (ack_wait > 0) begin
            ack_wait--;
         end else begin
            occ_ack  = 1'b1;
            occ_hit  = pick_hit();
            ack_wait = resp_rand ? int'($urandom_range(0, 3)) : 0;
         end
      end
      @(posedge clk);
      model_edge();
      #1;
      check_eq("step", 32'(step), 32'(m_step));
      check_eq("dir", 32'(dir), m_dir);
      check_eq("occ_query", 32'(occ_query), 32'(m_oq));
      check_eq("apple_valid", 32'(apple_valid), 32'(m_av));
      check_eq("apple_pos", 32'(apple_pos), m_apos);
      if (m_oq) check_eq("occ_pos", 32'(occ_pos), m_opos);
      if (occ_query && !prev_oq) begin
         n_queries++;
         last_qpos = occ_pos;
      end
      prev_oq = occ_query;
      if (step) n_steps++;
      frame_tick = 1'b0; key_valid = 1'b0; eat = 1'b0; init = 1'b0;
      occ_ack = 1'b0; occ_hit = 1'b0;
   endtask

   task automatic press(input logic [7:0] code);
      key_code = code; key_valid = 1'b1;
      cycle();
   endtask

   task automatic ticks(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         cycle();
         repeat (gap) cycle();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) cycle();
      rst = 1'b0;
   endtask

   logic [7:0] key_tab [6] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h12, 8'hF0};
   int         exp_sp [5];

   initial begin
`ifdef SNAKE_SPEEDUP_EN
      exp_sp = '{5, 4, 3, 2, 2};
`else
      exp_sp = '{5, 5, 5, 5, 5};
`endif
      // reset values
      run = 1'b0;
      do_reset();
      check_eq("rst_dir", 32'(dir), 3);
      check_eq("rst_apple_pos", 32'(apple_pos), 6);
      check_eq("rst_apple_valid", 32'(apple_valid), 0);

      // 10 ticks -> 2 steps, one cycle after the 5th and 10th tick
      run = 1'b1;
      n_steps = 0;
      for (int i = 1; i <= 10; i++) begin
         frame_tick = 1'b1;
         cycle();
         check_eq("step_after_tick", 32'(step), 32'((i % 5) == 0));
         cycle();
         check_eq("step_one_cycle", 32'(step), 0);
      end
      check_eq("step_count", n_steps, 2);
      check_eq("step_dir", 32'(dir), 3);

      // queue {up,left}; third key dropped on full queue
      press(8'h75);
      press(8'h6B);
      press(8'h72);
      ticks(5, 1);
      check_eq("q_first_pop", 32'(dir), 0);
      ticks(5, 1);
      check_eq("q_second_pop", 32'(dir), 2);
      ticks(5, 1);
      check_eq("q_third_dropped", 32'(dir), 2);

      // opposite and same keys rejected
      do_reset();
      run = 1'b1;
      press(8'h6B);
      press(8'h74);
      ticks(5, 1);
      check_eq("reject_rev_same", 32'(dir), 3);

      // 3 hits then a miss -> 4 queries, apple on the 4th cell
      run = 1'b0;
      hits_left = 3;
      init = 1'b1;
      cycle();
      n_queries = 0;
      repeat (30) cycle();
      check_eq("hit3_queries", n_queries, 4);
      check_eq("hit3_valid", 32'(apple_valid), 1);
      check_eq("hit3_pos", 32'(apple_pos), 32'(last_qpos));
      check_eq("hit3_x_range", 32'(apple_pos[6:0] <= 7'd63), 1);
      check_eq("hit3_y_range", 32'(apple_pos[12:7] <= 6'd47), 1);

      // always hit -> 16 queries then wait for a frame
      hits_left = -1;
      init = 1'b1;
      cycle();
      n_queries = 0;
      repeat (60) cycle();
      check_eq("allhit_queries", n_queries, 16);
      check_eq("allhit_valid", 32'(apple_valid), 0);
      check_eq("allhit_idle", 32'(occ_query), 0);
      hits_left = 0;
      frame_tick = 1'b1;
      cycle();
      repeat (6) cycle();
      check_eq("wait_restart_queries", n_queries, 17);
      check_eq("wait_restart_valid", 32'(apple_valid), 1);

      // init mid-query aborts; late ack ignored; key with init dropped
      resp_en = 1'b0;
      init = 1'b1;
      cycle();
      press(8'h75);
      for (int i = 0; i < 10 && !m_oq; i++) cycle();
      check_eq("abort_query_up", 32'(occ_query), 1);
      init = 1'b1; key_code = 8'h72; key_valid = 1'b1;
      cycle();
      check_eq("abort_query_drop", 32'(occ_query), 0);
      occ_ack = 1'b1; occ_hit = 1'b0;
      cycle();
      check_eq("late_ack_ignored", 32'(apple_valid), 0);
      check_eq("fresh_query", 32'(occ_query), 1);
      resp_en = 1'b1;
      run = 1'b1;
      ticks(5, 1);
      check_eq("abort_dir", 32'(dir), 3);

      // step spacing across eats
      init = 1'b1;
      cycle();
      repeat (4) cycle();
      for (int s = 0; s < 5; s++) begin
         int cnt;
         bit seen;
         cnt = 0;
         seen = 1'b0;
         while (!seen && cnt < 12) begin
            frame_tick = 1'b1;
            cycle();
            cnt++;
            if (step) seen = 1'b1;
            repeat (3) cycle();
         end
         check_eq("step_spacing", cnt, exp_sp[s]);
         check_eq("apple_before_eat", 32'(apple_valid), 1);
         eat = 1'b1;
         cycle();
         repeat (3) cycle();
      end

      // randomized traffic
      resp_rand = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (($urandom % 50) == 0) run = ~run;
         rst        = (($urandom % 500) == 0);
         init       = (($urandom % 200) == 0);
         frame_tick = (($urandom % 3) == 0);
         eat        = (($urandom % 8) == 0);
         if (($urandom % 4) == 0) begin
            key_valid = 1'b1;
            key_code  = key_tab[$urandom % 6];
         end
         cycle();
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
